// File: rtl/rs232_pkg.sv
// Shared constants, types and byte helpers for the RS-232 packet transmitter.
package rs232_pkg;

  localparam int unsigned PKT_BYTES          = 8;
  localparam int unsigned RX_HALF_CYCLES     = 3900;
  // One bit time is two thirds of the receiver's 1.5-bit sampling delay.
  localparam int unsigned BIT_CYCLES_DEFAULT = (RX_HALF_CYCLES * 2) / 3;
  localparam int unsigned CNT_W              = 13;
  localparam int unsigned IDX_W              = 3;
  localparam int unsigned DATA_W             = 32;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] PAD = 8'h00;

  // Bit-level phase of the byte serialiser.
  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_e;

  // Packet-level sequencing state.
  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_SEND = 2'd1,
    PKT_FIN  = 2'd2
  } pkt_state_e;

  // XOR of the four data bytes.
  function automatic logic [7:0] xor_chk(input logic [DATA_W-1:0] d);
    return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  // Byte at position idx of the response packet.
  function automatic logic [7:0] pkt_byte(input logic [IDX_W-1:0]  idx,
                                          input logic [DATA_W-1:0] hold,
                                          input logic [7:0]        chk);
    logic [7:0] b;
    case (idx)
      3'd0:    b = STX;
      3'd1:    b = hold[7:0];
      3'd2:    b = hold[15:8];
      3'd3:    b = hold[23:16];
      3'd4:    b = hold[31:24];
      3'd5:    b = chk;
      3'd6:    b = PAD;
      default: b = ETX;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first byte serialiser. A new byte may be loaded in the last cycle
// of the previous stop bit, so consecutive bytes leave no gap on the line.
module uart_tx_byte
  import rs232_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  bit_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;

  logic             bit_end_c;
  logic [IDX_W-1:0] bit_idx_inc_c;

  // Next-state: bit timing, bit sequencing and byte load.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    tx_d          = tx_q;
    bit_end_c     = (bit_cnt_q == CNT_LAST);
    bit_idx_inc_c = bit_idx_q + IDX_W'(1);

    if (state_q != BIT_IDLE) begin
      bit_cnt_d = bit_end_c ? '0 : bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      BIT_IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
      end
      BIT_START: begin
        if (bit_end_c) begin
          state_d   = BIT_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      BIT_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_W'(7)) begin
            state_d = BIT_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_inc_c;
            tx_d      = shreg_q[bit_idx_inc_c];
          end
        end
      end
      BIT_STOP: begin
        if (bit_end_c) begin
          state_d = BIT_IDLE;
        end
      end
      default: state_d = BIT_IDLE;
    endcase

    if (start && ready_q) begin
      state_d   = BIT_START;
      bit_cnt_d = '0;
      bit_idx_d = '0;
      shreg_d   = byte_in;
      tx_d      = 1'b0;
    end

    ready_d = (state_d == BIT_IDLE) ||
              ((state_d == BIT_STOP) && (bit_cnt_d == CNT_LAST));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BIT_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;

endmodule

// File: rtl/rs232_tx_packet.sv
// RS-232 response packet transmitter: STX, 4 data bytes, CHK, PAD, ETX.
// Optional macro RS232_TX_CHECKSUM_EN: CHK is the XOR of the data bytes,
// otherwise CHK is 0x00.
module rs232_tx_packet
  import rs232_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  pkt_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              byte_start_c;
  logic [7:0]        byte_data_c;
  logic [7:0]        chk_c;
  logic [IDX_W-1:0]  byte_idx_inc_c;
  logic              byte_tx;
  logic              byte_ready;

`ifdef RS232_TX_CHECKSUM_EN
  assign chk_c = xor_chk(hold_q);
`else
  assign chk_c = PAD;
`endif

  // Packet sequencing: accept a request, feed bytes back to back, then pulse done.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    byte_idx_d     = byte_idx_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    byte_start_c   = 1'b0;
    byte_data_c    = STX;
    byte_idx_inc_c = byte_idx_q + IDX_W'(1);

    case (state_q)
      PKT_IDLE: begin
        if (tx_start) begin
          hold_d       = data_in;
          byte_idx_d   = '0;
          busy_d       = 1'b1;
          state_d      = PKT_SEND;
          byte_start_c = 1'b1;
          byte_data_c  = STX;
        end
      end
      PKT_SEND: begin
        if (byte_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = PKT_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_idx_d   = byte_idx_inc_c;
            byte_start_c = 1'b1;
            byte_data_c  = pkt_byte(byte_idx_inc_c, hold_q, chk_c);
          end
        end
      end
      PKT_FIN: begin
        state_d = PKT_IDLE;
      end
      default: state_d = PKT_IDLE;
    endcase
  end

  // Packet state, hold register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PKT_IDLE;
      hold_q     <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .start  (byte_start_c),
    .byte_in(byte_data_c),
    .tx     (byte_tx),
    .ready  (byte_ready)
  );

  assign tx_out = byte_tx;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rs232_tx_packet.sv
// Scoreboard bench for rs232_tx_packet: a UART line decoder pops expected
// bytes pushed by the stimulus; a done watcher checks pulse timing.
module tb_rs232_tx_packet;

  localparam int BC       = 16;
  localparam int FRAME    = 10 * BC;
  localparam int PKT_CYC  = 80 * BC;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [31:0] data_in;
  logic        tx_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int exp_done_cyc  = -1;
  int done_cnt      = 0;
  int exp_done_tot  = 0;
  int frames_seen   = 0;
  int pkt_pos       = 0;
  int last_pkt_t0   = -1;
  int prev_frame_t  = -1;

  rs232_tx_packet #(.BIT_CYCLES(BC)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .data_in (data_in),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: expected byte stream of one packet.
  function automatic void push_packet(input logic [31:0] d);
    logic [7:0] chk;
    chk = 8'h00;
`ifdef RS232_TX_CHECKSUM_EN
    for (int k = 0; k < 4; k++) chk = chk ^ 8'((d >> (8 * k)) & 32'hFF);
`endif
    exp_q.push_back(8'h02);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((d >> (8 * k)) & 32'hFF));
    exp_q.push_back(chk);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
  endfunction

  // One-cycle request pulse; returns at the negedge of the following cycle.
  task automatic request(input logic [31:0] d, input bit accepted);
    @(negedge clk);
    tx_start = 1'b1;
    data_in  = d;
    if (accepted) begin
      push_packet(d);
      exp_done_tot++;
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, output int dcyc);
    int n;
    n = 0;
    dcyc = -1;
    while (n < 4 * PKT_CYC) begin
      @(negedge clk);
      if (scramble) data_in = $urandom;
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    check(dcyc >= 0, "done_timeout", dcyc, 1);
  endtask

  // Line decoder and scoreboard consumer.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] got, want;
    bit stable, aborted;
    int t;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx_out !== 1'b0) continue;
      t = cyc;
      frames_seen++;
      if (pkt_pos == 0) begin
        last_pkt_t0  = t;
        exp_done_cyc = t + PKT_CYC;
        check(busy === 1'b1, "busy_with_start", int'(busy), 1);
      end else begin
        check(t == prev_frame_t + FRAME, "byte_spacing", t - prev_frame_t, FRAME);
      end
      prev_frame_t = t;
      bits    = '0;
      stable  = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
        end
        if (k % BC == 0) bits[k / BC] = tx_out;
        else if (tx_out !== bits[k / BC]) stable = 1'b0;
      end
      if (aborted) begin
        pkt_pos = 0;
        continue;
      end
      check(stable, "bit_width", int'(stable), 1);
      check(bits[0] == 1'b0 && bits[9] == 1'b1, "framing", int'({bits[9], bits[0]}), 2);
      got = bits[8:1];
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_byte", int'(got), 0);
      end else begin
        want = exp_q.pop_front();
        check(got == want, $sformatf("byte%0d", pkt_pos), int'(got), int'(want));
      end
      pkt_pos = (pkt_pos + 1) % 8;
    end
  end

  // Done pulse watcher: exactly one cycle, at the expected time, with busy low.
  initial begin : done_watch
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        exp_done_cyc = -1;
      end else if (done === 1'b1) begin
        done_cnt++;
        check(cyc == exp_done_cyc, "done_timing", cyc, exp_done_cyc);
        check(busy === 1'b0 && tx_out === 1'b1, "fin_outputs", int'({busy, tx_out}), 1);
        exp_done_cyc = -1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int d1, d2, snap_done, snap_frames, f;
    bit idle_ok;
    logic [31:0] rd;

    rst = 1'b1;
    tx_start = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset idle
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    check(idle_ok, "reset_idle", int'({tx_out, busy, done}), 4);

    // Single packet, then a request during FIN that must be ignored
    request(32'h44332211, 1'b1);
    wait_done(1'b0, d1);
    check(d1 == last_pkt_t0 + PKT_CYC, "single_done_latency", d1 - last_pkt_t0, PKT_CYC);
    snap_frames = frames_seen;
    tx_start = 1'b1;
    data_in  = 32'h55555555;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (200) @(negedge clk);
    check(frames_seen == snap_frames && busy === 1'b0, "fin_request_ignored",
          frames_seen - snap_frames, 0);

    // Busy collision
    snap_done = done_cnt;
    request(32'h0BADF00D, 1'b1);
    repeat (498) @(negedge clk);
    request(32'hDEADBEEF, 1'b0);
    wait_done(1'b0, d1);
    repeat (200) @(negedge clk);
    check(done_cnt == snap_done + 1, "collision_one_done", done_cnt - snap_done, 1);

    // Back-to-back
    request(32'h00C0FFEE, 1'b1);
    wait_done(1'b0, d1);
    request(32'h000000FF, 1'b1);
    wait_done(1'b0, d2);
    check(last_pkt_t0 == d1 + 2, "b2b_gap", last_pkt_t0 - d1, 2);

    // Mid-packet reset
    snap_done = done_cnt;
    request(32'h5A5A1234, 1'b1);
    exp_done_tot--;
    f = cyc;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check(tx_out === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_abort_line",
          int'({tx_out, busy, done}), 4);
    check(cyc - f == 301, "reset_abort_cycle", cyc - f, 301);
    repeat (1500) @(negedge clk);
    check(done_cnt == snap_done, "reset_no_done", done_cnt - snap_done, 0);
    request(32'hA5A5A5A5, 1'b1);
    wait_done(1'b0, d1);

    // Input hold while data_in changes every cycle
    request(32'h12345678, 1'b1);
    wait_done(1'b1, d1);

    // Random packets with random idle gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(20, 1)) @(negedge clk);
      rd = $urandom;
      request(rd, 1'b1);
      wait_done(1'b0, d1);
    end

    repeat (50) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    check(done_cnt == exp_done_tot, "done_count", done_cnt, exp_done_tot);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
